// File: rtl/timer_rr_scheduler.sv
// timer_rr_scheduler: shares one single-shot wait timer between NREQ
// requesters. Pending requests are granted round-robin; the winner's job
// arms the timer, waits for READY, pulses DONE and returns the timer to idle.
// A watchdog raises a sticky ERR if the timer stays silent for TIMEOUT cycles.
module timer_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int TMR_N   = 256,
    parameter int TIMEOUT = 2 * TMR_N
) (
    input  logic            CLK,
    input  logic            N_RESET,
    input  logic [NREQ-1:0] REQ,
    output logic [NREQ-1:0] GNT,
    output logic [NREQ-1:0] DONE,
    output logic            BUSY,
    output logic            ERR,
    output logic            TMR_START,
    output logic            TMR_RESET,
    input  logic            TMR_READY
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [LW-1:0]   r_last;
    logic [LW-1:0]   w_last_nxt;
    logic [WW-1:0]   r_wdog;
    logic [WW-1:0]   w_wdog_nxt;
    logic            r_err;
    logic            w_err_nxt;

    logic [LW-1:0]   w_win;
    logic [LW-1:0]   w_idx;
    logic [NREQ-1:0] w_onehot;

    // Round-robin pick: scan offsets NREQ..1 so the smallest offset from
    // (last+1) that has a request overwrites any later candidate.
    always_comb begin
        w_win    = r_last;
        w_idx    = '0;
        w_onehot = '0;
        for (int unsigned i = NREQ; i >= 1; i--) begin
            w_idx = LW'((32'(r_last) + i) % NREQ);
            if (REQ[w_idx]) begin
                w_win = w_idx;
            end
        end
        w_onehot[w_win] = 1'b1;
    end

    // Next-state, grant, pointer and watchdog decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_wdog_nxt  = r_wdog;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (|REQ) begin
                    w_gnt_nxt   = w_onehot;
                    w_last_nxt  = w_win;
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                w_wdog_nxt  = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (TMR_READY) begin
                    w_wdog_nxt  = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    if (r_wdog != WW'(TIMEOUT)) begin
                        w_wdog_nxt = r_wdog + 1'b1;
                    end
                    // ERR rises on the same edge the counter reaches TIMEOUT.
                    if (r_wdog >= WW'(TIMEOUT - 1)) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous active-low clear.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_last  <= LW'(NREQ - 1);
            r_wdog  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_wdog  <= w_wdog_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Moore outputs decoded from registered state and grant.
    always_comb begin
        GNT       = r_gnt;
        DONE      = (r_state == S_DONE) ? r_gnt : '0;
        BUSY      = (r_state != S_IDLE);
        ERR       = r_err;
        TMR_START = (r_state == S_ARM);
        TMR_RESET = (r_state == S_DONE);
    end

endmodule

// File: tb/tb_timer_rr_scheduler.sv
// Directed bench for timer_rr_scheduler with TMR_N=8, TIMEOUT=16 and a
// behavioural single-shot timer that can be replaced by a READY stub.
module tb_timer_rr_scheduler;

    localparam int NREQ    = 4;
    localparam int TMR_N   = 8;
    localparam int TIMEOUT = 16;

    logic            CLK     = 1'b0;
    logic            N_RESET = 1'b0;
    logic [NREQ-1:0] REQ     = '0;
    logic [NREQ-1:0] GNT;
    logic [NREQ-1:0] DONE;
    logic            BUSY;
    logic            ERR;
    logic            TMR_START;
    logic            TMR_RESET;
    logic            TMR_READY;

    logic [7:0]      t_cnt;
    logic            stub_en  = 1'b0;
    logic            stub_rdy = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    timer_rr_scheduler #(
        .NREQ   (NREQ),
        .TMR_N  (TMR_N),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .N_RESET  (N_RESET),
        .REQ      (REQ),
        .GNT      (GNT),
        .DONE     (DONE),
        .BUSY     (BUSY),
        .ERR      (ERR),
        .TMR_START(TMR_START),
        .TMR_RESET(TMR_RESET),
        .TMR_READY(TMR_READY)
    );

    always #5 CLK = ~CLK;

    // Single-shot timer: START loads 1, counts to N-1 and holds READY until RESET.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            t_cnt <= '0;
        end else if (TMR_RESET) begin
            t_cnt <= '0;
        end else if (TMR_START) begin
            t_cnt <= 8'd1;
        end else if (t_cnt != 8'd0 && t_cnt < 8'(TMR_N - 1)) begin
            t_cnt <= t_cnt + 8'd1;
        end
    end

    assign TMR_READY = stub_en ? stub_rdy : (t_cnt == 8'(TMR_N - 1));

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (DONE != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        N_RESET = 1'b0;
        REQ     = '0;
        repeat (2) step();
        N_RESET = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if ({GNT, DONE, BUSY, TMR_START, TMR_RESET, ERR} !== '0) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: GNT=%b DONE=%b BUSY=%b START=%b RST=%b ERR=%b, want all 0",
                         i, GNT, DONE, BUSY, TMR_START, TMR_RESET, ERR);
            end
        end
        stub_en  = 1'b1;
        stub_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (BUSY !== 1'b0 || ERR !== 1'b0 || DONE !== '0) begin
                n_err++;
                $display("FAIL ready_in_idle[%0d]: BUSY=%b ERR=%b DONE=%b, want 0 0 0000", i, BUSY, ERR, DONE);
            end
        end
        stub_en  = 1'b0;
        stub_rdy = 1'b0;
    endtask

    task automatic test_single();
        REQ = 4'b0100;
        step();
        n_cmp++;
        if (GNT !== 4'b0100 || TMR_START !== 1'b1 || BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL single_e0: GNT=%b START=%b BUSY=%b, want 0100 1 1", GNT, TMR_START, BUSY);
        end
        for (int k = 1; k <= 7; k++) begin
            step();
            n_cmp++;
            if (GNT !== 4'b0100 || TMR_START !== 1'b0 || TMR_RESET !== 1'b0 || DONE !== '0) begin
                n_err++;
                $display("FAIL single_wait_e%0d: GNT=%b START=%b RST=%b DONE=%b, want 0100 0 0 0000",
                         k, GNT, TMR_START, TMR_RESET, DONE);
            end
        end
        step();
        n_cmp++;
        if (DONE !== 4'b0100 || TMR_RESET !== 1'b1 || TMR_START !== 1'b0) begin
            n_err++;
            $display("FAIL single_e8: DONE=%b RST=%b START=%b, want 0100 1 0", DONE, TMR_RESET, TMR_START);
        end
        REQ = '0;
        step();
        n_cmp++;
        if (BUSY !== 1'b0 || GNT !== '0 || DONE !== '0) begin
            n_err++;
            $display("FAIL single_e9: BUSY=%b GNT=%b DONE=%b, want 0 0000 0000", BUSY, GNT, DONE);
        end
    endtask

    task automatic test_rr_all();
        logic [3:0] g_val [8];
        int         g_cyc [8];
        int         ng;
        int         nd;
        logic [3:0] prev;
        logic [3:0] exp_g;
        ng   = 0;
        nd   = 0;
        prev = '0;
        N_RESET = 1'b0;
        step();
        N_RESET = 1'b1;
        REQ = 4'b1111;
        for (int c = 0; c < 50; c++) begin
            step();
            if (GNT != '0 && prev == '0) begin
                if (ng < 8) begin
                    g_val[ng] = GNT;
                    g_cyc[ng] = c;
                end
                ng++;
            end
            prev = GNT;
            if (DONE != '0) nd++;
            n_cmp++;
            if ((DONE & ~GNT) != '0 || (TMR_START && TMR_RESET)) begin
                n_err++;
                $display("FAIL rr_invariant[%0d]: DONE=%b GNT=%b START=%b RST=%b, want DONE subset of GNT, not both",
                         c, DONE, GNT, TMR_START, TMR_RESET);
            end
        end
        REQ = '0;
        n_cmp++;
        if (ng != 5 || nd != 5) begin
            n_err++;
            $display("FAIL rr_counts: grants=%0d done_pulses=%0d, want 5 5", ng, nd);
        end
        for (int j = 0; j < 5; j++) begin
            if (j < ng) begin
                exp_g = 4'b0001 << (j % 4);
                n_cmp++;
                if (g_val[j] !== exp_g || g_cyc[j] != 10 * j) begin
                    n_err++;
                    $display("FAIL rr_order[%0d]: GNT=%b at cycle %0d, want %b at cycle %0d",
                             j, g_val[j], g_cyc[j], exp_g, 10 * j);
                end
            end
        end
        step();
    endtask

    task automatic test_rr_priority();
        bit ok;
        REQ = 4'b0010;
        step();
        wait_done(ok);
        REQ = '0;
        n_cmp++;
        if (!ok || DONE !== 4'b0010) begin
            n_err++;
            $display("FAIL prio_setup: done_seen=%0d DONE=%b, want 1 0010", ok, DONE);
        end
        step();
        REQ = 4'b1001;
        step();
        n_cmp++;
        if (GNT !== 4'b1000) begin
            n_err++;
            $display("FAIL prio_wrap: GNT=%b, want 1000", GNT);
        end
        wait_done(ok);
        n_cmp++;
        if (!ok || DONE !== 4'b1000) begin
            n_err++;
            $display("FAIL prio_done3: done_seen=%0d DONE=%b, want 1 1000", ok, DONE);
        end
        REQ = 4'b0001;
        step();
        step();
        n_cmp++;
        if (GNT !== 4'b0001) begin
            n_err++;
            $display("FAIL prio_req0: GNT=%b, want 0001", GNT);
        end
        wait_done(ok);
        REQ = '0;
        step();
    endtask

    task automatic test_watchdog();
        logic exp_e;
        stub_en  = 1'b1;
        stub_rdy = 1'b0;
        REQ      = 4'b0001;
        step();
        n_cmp++;
        if (GNT !== 4'b0001) begin
            n_err++;
            $display("FAIL wdog_grant: GNT=%b, want 0001", GNT);
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_e = (k >= 17);
            n_cmp++;
            if (ERR !== exp_e || BUSY !== 1'b1 || DONE !== '0) begin
                n_err++;
                $display("FAIL wdog_e%0d: ERR=%b BUSY=%b DONE=%b, want %b 1 0000", k, ERR, BUSY, DONE, exp_e);
            end
        end
        stub_rdy = 1'b1;
        step();
        n_cmp++;
        if (DONE !== 4'b0001 || ERR !== 1'b1) begin
            n_err++;
            $display("FAIL wdog_done: DONE=%b ERR=%b, want 0001 1", DONE, ERR);
        end
        REQ      = '0;
        stub_rdy = 1'b0;
        step();
        n_cmp++;
        if (BUSY !== 1'b0 || ERR !== 1'b1) begin
            n_err++;
            $display("FAIL wdog_sticky: BUSY=%b ERR=%b, want 0 1", BUSY, ERR);
        end
    endtask

    task automatic test_abort();
        bit ok;
        stub_en  = 1'b1;
        stub_rdy = 1'b0;
        REQ      = 4'b0100;
        repeat (5) step();
        #2;
        N_RESET = 1'b0;
        #1;
        n_cmp++;
        if ({GNT, DONE, BUSY, TMR_START, TMR_RESET, ERR} !== '0) begin
            n_err++;
            $display("FAIL abort_async: GNT=%b DONE=%b BUSY=%b START=%b RST=%b ERR=%b, want all 0",
                     GNT, DONE, BUSY, TMR_START, TMR_RESET, ERR);
        end
        REQ = 4'b0010;
        step();
        n_cmp++;
        if (DONE !== '0 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL abort_hold: DONE=%b BUSY=%b, want 0000 0", DONE, BUSY);
        end
        N_RESET = 1'b1;
        stub_en = 1'b0;
        step();
        n_cmp++;
        if (GNT !== 4'b0010 || ERR !== 1'b0) begin
            n_err++;
            $display("FAIL abort_regrant: GNT=%b ERR=%b, want 0010 0", GNT, ERR);
        end
        wait_done(ok);
        n_cmp++;
        if (!ok || DONE !== 4'b0010 || ERR !== 1'b0) begin
            n_err++;
            $display("FAIL abort_job: done_seen=%0d DONE=%b ERR=%b, want 1 0010 0", ok, DONE, ERR);
        end
        REQ = '0;
        step();
        n_cmp++;
        if (BUSY !== 1'b0 || ERR !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: BUSY=%b ERR=%b, want 0 0", BUSY, ERR);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_all();
        test_rr_priority();
        test_watchdog();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
